// File: rtl/vram_pkg.sv
// Shared constants and types for the VRAM arbiter slice.
package vram_pkg;

  // Default VRAM geometry: 80x60 tile entries, one byte per entry.
  localparam int unsigned VRAM_ADDR_W = 13;
  localparam int unsigned VRAM_DATA_W = 8;

  // Fixed video fetch latency from vid_req to vid_rvalid, in cycles.
  localparam int unsigned VID_LAT = 3;

  // Host-side access sequencer states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_ACK = 3'd1,
    RD_W1  = 3'd2,
    RD_W2  = 3'd3,
    RD_ACK = 3'd4
  } arb_state_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of video fetch, host handshake and RAM port signals around vram_arbiter.
interface vram_arbiter_if
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_ADDR_W,
  parameter int unsigned DATA_W = VRAM_DATA_W
);

  logic              blank;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Arbiter view.
  modport slave (
    input  blank, vid_req, vid_addr, host_req, host_we, host_addr, host_wdata, ram_rdata,
    output vid_rvalid, vid_rdata, host_ack, host_rdata, ram_en, ram_we, ram_addr, ram_wdata
  );

  // Environment view (renderer, host and RAM together).
  modport master (
    output blank, vid_req, vid_addr, host_req, host_we, host_addr, host_wdata, ram_rdata,
    input  vid_rvalid, vid_rdata, host_ack, host_rdata, ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/vram_rd_pipe.sv
// Two-stage valid/tag pipeline that follows each RAM read to its data cycle and
// steers the captured word to the video or host read register.
module vram_rd_pipe #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_rd_valid,
  input  logic              i_rd_host,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_vid_rvalid,
  output logic [DATA_W-1:0] o_vid_rdata,
  output logic [DATA_W-1:0] o_host_rdata
);

  // Stage 0 is the cycle the RAM sees the address, stage 1 the cycle its data is valid.
  logic [1:0] r_valid;
  logic [1:0] r_host;

  // Shift issued reads along; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid <= 2'b00;
      r_host  <= 2'b00;
    end else begin
      r_valid <= {r_valid[0], i_rd_valid};
      r_host  <= {r_host[0], i_rd_host};
    end
  end

  // Capture RAM data into the owner's register; the other side holds.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_vid_rvalid <= 1'b0;
      o_vid_rdata  <= '0;
      o_host_rdata <= '0;
    end else begin
      o_vid_rvalid <= r_valid[1] & ~r_host[1];
      if (r_valid[1] && !r_host[1]) begin
        o_vid_rdata <= i_ram_rdata;
      end
      if (r_valid[1] && r_host[1]) begin
        o_host_rdata <= i_ram_rdata;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: beam-locked video fetch with absolute priority and
// fixed 3-cycle latency, host req/ack port filling the free cycles.
// Optional feature macro: VRAM_BLANK_ONLY_EN restricts host grants to blanking.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_ADDR_W,
  parameter int unsigned DATA_W = VRAM_DATA_W
) (
  input  logic clk,
  input  logic reset_n,
  vram_arbiter_if.slave bus
);

  arb_state_t        r_state;
  logic              r_ram_en;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_host_ack;

  logic              w_blank_ok;
  logic              w_host_grant;
  logic              w_rd_issue;
  logic              w_rd_host;
  logic              w_vid_rvalid;
  logic [DATA_W-1:0] w_vid_rdata;
  logic [DATA_W-1:0] w_host_rdata;

`ifdef VRAM_BLANK_ONLY_EN
  // Host may only start an access while the beam is outside the visible area.
  assign w_blank_ok = bus.blank;
`else
  logic w_unused_blank;
  assign w_blank_ok     = 1'b1;
  assign w_unused_blank = bus.blank;
`endif

  // Host wins only an idle sequencer in a cycle with no video fetch.
  assign w_host_grant = (r_state == IDLE) && bus.host_req && !bus.vid_req && w_blank_ok;
  assign w_rd_issue   = bus.vid_req || (w_host_grant && !bus.host_we);
  assign w_rd_host    = !bus.vid_req;

  // Host sequencer and registered RAM port.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_host_ack  <= 1'b0;
    end else begin
      r_ram_en   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_host_ack <= 1'b0;

      if (bus.vid_req) begin
        r_ram_en   <= 1'b1;
        r_ram_addr <= bus.vid_addr;
      end else if (w_host_grant) begin
        r_ram_en    <= 1'b1;
        r_ram_we    <= bus.host_we;
        r_ram_addr  <= bus.host_addr;
        r_ram_wdata <= bus.host_wdata;
      end

      case (r_state)
        IDLE: begin
          if (w_host_grant) begin
            if (bus.host_we) begin
              r_state    <= WR_ACK;
              r_host_ack <= 1'b1;
            end else begin
              r_state <= RD_W1;
            end
          end
        end
        WR_ACK: r_state <= IDLE;
        RD_W1:  r_state <= RD_W2;
        RD_W2: begin
          r_state    <= RD_ACK;
          r_host_ack <= 1'b1;
        end
        RD_ACK:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read data return path, tagged per requester.
  vram_rd_pipe #(
    .DATA_W (DATA_W)
  ) u_rd_pipe (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_rd_valid   (w_rd_issue),
    .i_rd_host    (w_rd_host),
    .i_ram_rdata  (bus.ram_rdata),
    .o_vid_rvalid (w_vid_rvalid),
    .o_vid_rdata  (w_vid_rdata),
    .o_host_rdata (w_host_rdata)
  );

  assign bus.ram_en     = r_ram_en;
  assign bus.ram_we     = r_ram_we;
  assign bus.ram_addr   = r_ram_addr;
  assign bus.ram_wdata  = r_ram_wdata;
  assign bus.host_ack   = r_host_ack;
  assign bus.host_rdata = w_host_rdata;
  assign bus.vid_rvalid = w_vid_rvalid;
  assign bus.vid_rdata  = w_vid_rdata;

endmodule
